// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 sliding-window generator over a raster pixel stream (two line buffers + window).
// Latency: window registered 1 cycle after the accept of its bottom-right pixel.
// Backpressure: pix_ready high only while streaming; no output backpressure (core always accepts).
module conv_window_gen_3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [DATA_W-1:0] pix_in,
    output logic signed [DATA_W-1:0] win0,
    output logic signed [DATA_W-1:0] win1,
    output logic signed [DATA_W-1:0] win2,
    output logic signed [DATA_W-1:0] win3,
    output logic signed [DATA_W-1:0] win4,
    output logic signed [DATA_W-1:0] win5,
    output logic signed [DATA_W-1:0] win6,
    output logic signed [DATA_W-1:0] win7,
    output logic signed [DATA_W-1:0] win8,
    output logic                     win_valid,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                   state;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic signed [DATA_W-1:0] lb0 [IMG_W];
    logic signed [DATA_W-1:0] lb1 [IMG_W];

    // The two most recently completed window columns (ca older, cb newer), top/mid/bottom.
    logic signed [DATA_W-1:0] ca_t, ca_m, ca_b;
    logic signed [DATA_W-1:0] cb_t, cb_m, cb_b;

    logic                     accept;
    logic                     last_pix;
    logic                     qualify;
    logic signed [DATA_W-1:0] lb0_rd;
    logic signed [DATA_W-1:0] lb1_rd;

    assign accept   = pix_valid && pix_ready;
    assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign qualify  = (row >= RW'(2)) && (col >= CW'(2));
    // Asynchronous read before the clocked write gives read-old-data on same-address access.
    assign lb0_rd   = lb0[col];
    assign lb1_rd   = lb1[col];

    // Line-buffer update on every accepted pixel; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= pix_in;
        end
    end

    // Control FSM, raster counters, column history and registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            ca_t <= '0; ca_m <= '0; ca_b <= '0;
            cb_t <= '0; cb_m <= '0; cb_b <= '0;
            win0 <= '0; win1 <= '0; win2 <= '0;
            win3 <= '0; win4 <= '0; win5 <= '0;
            win6 <= '0; win7 <= '0; win8 <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        col       <= '0;
                        row       <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (col == CW'(IMG_W - 1)) begin
                            col <= '0;
                            row <= last_pix ? '0 : row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        ca_t <= cb_t;   ca_m <= cb_m;   ca_b <= cb_b;
                        cb_t <= lb1_rd; cb_m <= lb0_rd; cb_b <= pix_in;
                        // Outputs only move on qualifying beats so they hold between pulses.
                        if (qualify) begin
                            win0 <= ca_t; win1 <= cb_t; win2 <= lb1_rd;
                            win3 <= ca_m; win4 <= cb_m; win5 <= lb0_rd;
                            win6 <= ca_b; win7 <= cb_b; win8 <= pix_in;
                            win_valid  <= 1'b1;
                            frame_done <= last_pix;
                        end
                        if (last_pix) begin
                            state     <= DONE;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Scoreboard bench for conv_window_gen_3x3: a 4x4 instance and a default 28x28 instance.
// Expected windows are sliced from a software image on each qualifying accept.
// Valid gaps come from fixed toggling or $urandom; outputs are sampled on the falling edge.
module tb_conv_window_gen_3x3;

    typedef struct {
        logic [71:0] win;
        bit          fd;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pv;
    logic [7:0] px;
    bit         sel;          // 0: 4x4 instance, 1: 28x28 instance

    logic       rdy4, wv4, fd4, busy4;
    logic       rdy28, wv28, fd28, busy28;
    logic [7:0] a4 [9];
    logic [7:0] a28 [9];

    exp_t q4[$];
    exp_t q28[$];
    int   img [0:783];
    int   cyc = 0;
    int   nwin4 = 0, nwin28 = 0, nfd4 = 0, nfd28 = 0;
    int   n_vec = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_gen_3x3 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .start(start && !sel), .pix_valid(pv && !sel),
        .pix_ready(rdy4), .pix_in(px),
        .win0(a4[0]), .win1(a4[1]), .win2(a4[2]), .win3(a4[3]), .win4(a4[4]),
        .win5(a4[5]), .win6(a4[6]), .win7(a4[7]), .win8(a4[8]),
        .win_valid(wv4), .frame_done(fd4), .busy(busy4)
    );

    conv_window_gen_3x3 dut28 (
        .clk(clk), .rst(rst), .start(start && sel), .pix_valid(pv && sel),
        .pix_ready(rdy28), .pix_in(px),
        .win0(a28[0]), .win1(a28[1]), .win2(a28[2]), .win3(a28[3]), .win4(a28[4]),
        .win5(a28[5]), .win6(a28[6]), .win7(a28[7]), .win8(a28[8]),
        .win_valid(wv28), .frame_done(fd28), .busy(busy28)
    );

    function automatic logic [71:0] pack(input logic [7:0] a [9]);
        logic [71:0] p;
        for (int k = 0; k < 9; k++) p[(8-k)*8 +: 8] = a[k];
        return p;
    endfunction

    function automatic void cmp(input string name, input logic [71:0] act, input logic [71:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: pop one expected window per win_valid pulse and compare content, frame_done and timing.
    always @(negedge clk) begin
        exp_t e;
        if (fd4) cmp("fd4_needs_win_valid", 72'(wv4), 72'd1);
        if (fd28) cmp("fd28_needs_win_valid", 72'(wv28), 72'd1);
        if (wv4) begin
            nwin4++;
            if (fd4) nfd4++;
            if (q4.size() == 0) cmp("win4_unexpected_pulse", 72'(q4.size()), 72'd1);
            else begin
                e = q4.pop_front();
                cmp("win4_data", pack(a4), e.win);
                cmp("win4_frame_done", 72'(fd4), 72'(e.fd));
                cmp("win4_latency", 72'(cyc), 72'(e.cyc));
            end
        end
        if (wv28) begin
            nwin28++;
            if (fd28) nfd28++;
            if (q28.size() == 0) cmp("win28_unexpected_pulse", 72'(q28.size()), 72'd1);
            else begin
                e = q28.pop_front();
                cmp("win28_data", pack(a28), e.win);
                cmp("win28_frame_done", 72'(fd28), 72'(e.fd));
                cmp("win28_latency", 72'(cyc), 72'(e.cyc));
            end
        end
    end

    function automatic logic rdy_s();
        return sel ? rdy28 : rdy4;
    endfunction

    function automatic logic busy_s();
        return sel ? busy28 : busy4;
    endfunction

    // mode 0: back-to-back, 1: toggle valid each cycle, 2: random gaps.
    task automatic run_frame(input bit s, input int w, input int h, input int mode,
                             input int stop_after, input bit poke_start);
        int   idx = 0, guard = 0, r, c, n0, f0, q0;
        bit   acc;
        exp_t e;
        sel = s;
        n0  = s ? nwin28 : nwin4;
        f0  = s ? nfd28 : nfd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pv = 1'b0;
        while (idx < w*h && idx != stop_after && guard < 5000) begin
            case (mode)
                0:       pv = 1'b1;
                1:       pv = ~pv;
                default: pv = ($urandom_range(0, 3) != 0);
            endcase
            px    = 8'(img[idx]);
            start = poke_start && (idx == 5);
            acc   = pv && rdy_s();
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                r = idx / w;
                c = idx % w;
                if (r >= 2 && c >= 2) begin
                    for (int k = 0; k < 9; k++)
                        e.win[(8-k)*8 +: 8] = 8'(img[(r-2+k/3)*w + (c-2+k%3)]);
                    e.fd  = (idx == w*h-1);
                    e.cyc = cyc;
                    if (s) q28.push_back(e); else q4.push_back(e);
                end
                if (idx == w*h-1) begin
                    cmp("ready_low_in_done", 72'(rdy_s()), 72'd0);
                    cmp("busy_high_in_done", 72'(busy_s()), 72'd1);
                end
                idx++;
            end
        end
        pv = 1'b0;
        start = 1'b0;
        if (guard >= 5000) cmp("frame_timeout_pixels", 72'(idx), 72'(w*h));
        if (idx == w*h) begin
            @(posedge clk); #1;
            cmp("busy_low_after_done", 72'(busy_s()), 72'd0);
            repeat (3) @(posedge clk);
            #1;
            q0 = s ? q28.size() : q4.size();
            cmp("windows_per_frame", 72'((s ? nwin28 : nwin4) - n0), 72'((w-2)*(h-2)));
            cmp("frame_done_count", 72'((s ? nfd28 : nfd4) - f0), 72'd1);
            cmp("scoreboard_drained", 72'(q0), 72'd0);
        end
    endtask

    task automatic check_cleared(input string tag);
        cmp({tag, "_win4"}, pack(a4), 72'd0);
        cmp({tag, "_win28"}, pack(a28), 72'd0);
        cmp({tag, "_flags4"}, {68'd0, wv4, fd4, rdy4, busy4}, 72'd0);
        cmp({tag, "_flags28"}, {68'd0, wv28, fd28, rdy28, busy28}, 72'd0);
    endtask

    initial begin
        int n_before;
        rst = 1'b1; sel = 1'b0; start = 1'b0; pv = 1'b0; px = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 4x4 ramp 1..16, back-to-back then toggling valid.
        for (int i = 0; i < 16; i++) img[i] = i + 1;
        run_frame(1'b0, 4, 4, 0, -1, 1'b0);
        run_frame(1'b0, 4, 4, 1, -1, 1'b0);

        // start poked mid-stream, random pixels and random gaps.
        for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(1'b0, 4, 4, 2, -1, 1'b1);

        // Negative pixels -1..-16.
        for (int i = 0; i < 16; i++) img[i] = -(i + 1);
        run_frame(1'b0, 4, 4, 0, -1, 1'b0);

        // Reset after pixel 10, then a fresh frame 101..116.
        for (int i = 0; i < 16; i++) img[i] = i + 1;
        run_frame(1'b0, 4, 4, 0, 10, 1'b0);
        n_before = nwin4;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_cleared("mid_reset");
        repeat (6) @(posedge clk);
        #1;
        cmp("no_window_after_reset", 72'(nwin4 - n_before), 72'd0);
        cmp("no_pending_after_reset", 72'(q4.size()), 72'd0);
        for (int i = 0; i < 16; i++) img[i] = 101 + i;
        run_frame(1'b0, 4, 4, 0, -1, 1'b0);

        // Default 28x28: pattern frame, then a random frame reusing the line buffers.
        for (int i = 0; i < 784; i++) img[i] = ((i / 28) * 28 + (i % 28)) % 128;
        run_frame(1'b1, 28, 28, 0, -1, 1'b0);
        for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(1'b1, 28, 28, 2, -1, 1'b0);

        cmp("final_q4_empty", 72'(q4.size()), 72'd0);
        cmp("final_q28_empty", 72'(q28.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen_3x3.md
Name: conv_window_gen_3x3

Overview:
Streaming 3x3 sliding-window generator that feeds the parallel 3x3 convolution core.
- Accepts a raster-order pixel stream (row-major, one pixel per accepted beat).
- Buffers two image lines plus a 3x3 register window.
- Emits one complete 9-pixel window per accepted pixel once the window is fully inside the frame ("valid" convolution, no padding).
- Outputs map 1:1 onto the convolution core's in0..in8 and valid_in.

Parameters:
IMG_W, 28, pixels per row (must be >= 3)
IMG_H, 28, rows per frame (must be >= 3)
DATA_W, 8, pixel width (signed, passed through unmodified)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when in IDLE
pix_valid  in  1  input pixel valid
pix_ready  out  1  generator can accept a pixel
pix_in  in  DATA_W  signed input pixel, raster order
win0..win8  out  DATA_W each  signed window pixels, row-major; win0 = top-left, win8 = bottom-right
win_valid  out  1  window outputs valid this cycle
frame_done  out  1  one-cycle pulse coincident with the last win_valid of a frame
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state=IDLE; col and row counters = 0.
  - win0..win8 = 0; win_valid, frame_done, pix_ready and busy = 0.
  - Line-buffer contents are not reset; stale data is masked by the counters.
- States: IDLE -> STREAM -> DONE -> IDLE.
  - IDLE: pix_ready=0. start=1 -> STREAM next cycle with col=row=0.
  - STREAM: pix_ready=1. A beat is accepted when pix_valid && pix_ready.
  - STREAM exits to DONE after accepting pixel (IMG_H-1, IMG_W-1).
  - DONE: pix_ready=0; lasts exactly 1 cycle, then IDLE.
  - start outside IDLE is ignored.
- Counters: on each accept, col increments. At col=IMG_W-1, col wraps to 0 and row increments. Counter widths are $clog2 of the dimension.
- Datapath, on each accept of pixel p at (row r, col c):
  - New window right column = {lb1[c], lb0[c], p}, top to bottom.
  - Window shifts one column left, discarding the left column.
  - lb1[c] <= lb0[c]; lb0[c] <= p.
  - The line buffers are IMG_W-deep; they may be implemented as registers or distributed RAM, but a read and a write of the same address in one cycle must return the old data.
- Window valid condition: accept with r >= 2 and c >= 2.
  - win_valid is registered and asserts 1 cycle after that accept.
  - win0..win8 then hold pixels (r-2..r, c-2..c).
  - Stale columns at row start are never exposed, because c >= 2 is required.
- Output hold: when win_valid=0, win0..win8 hold their last values. win_valid and frame_done are 1-cycle pulses per accepted qualifying beat.
- Throughput and count:
  - Up to 1 window per cycle; gaps in pix_valid produce matching gaps in win_valid.
  - No output backpressure; the convolution core always accepts.
  - Windows per frame = (IMG_W-2)*(IMG_H-2).
- frame_done asserts in the same cycle as the win_valid for pixel (IMG_H-1, IMG_W-1), which is the cycle DONE is occupied.
- Reset mid-frame: everything returns to reset values on the next edge; no partial window is emitted afterwards. A new start is required.
- pix_in is ignored whenever pix_ready=0.

Test Plan:
1. IMG_W=IMG_H=4; start, then pixels 1..16 back-to-back -> exactly 4 win_valid pulses, as below.
   - First, 1 cycle after pixel 11 is accepted: {1,2,3,5,6,7,9,10,11}.
   - Then {2,3,4,6,7,8,10,11,12} and {5,6,7,9,10,11,13,14,15}.
   - Last: {6,7,8,10,11,12,14,15,16} with frame_done=1.
   - pix_ready=0 the cycle after pixel 16 is accepted; busy=0 one cycle later.
2. Same frame with pix_valid toggling 1/0 each cycle -> identical 4 windows, each 1 cycle after its qualifying accept, with no extra pulses.
3. Default 28x28 with pixel value = (r*28+c) mod 128:
   - Exactly 676 win_valid pulses; every window checked against a software 3x3 slice.
   - Single frame_done pulse.
   - Then a second back-to-back frame also gives 676 correct windows (line buffers reused).
4. start pulsed while busy=1 in STREAM -> ignored; counters and window sequence unchanged.
5. rst asserted after pixel 10 of a 4x4 frame -> next cycle all outputs 0 and busy=0. No win_valid until a new start. A fresh frame of 101..116 gives first window {101,102,103,105,106,107,109,110,111}.
6. Negative pixels: 4x4 frame of values -1..-16 -> windows carry exact signed values, e.g. first window win0=-1 (8'hFF), win8=-11 (8'hF5).
